// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the oversampling UART receiver and its transmitter
// counterpart:
//   - OS          : oversampling ticks per bit (fixed at 16, must be even)
//   - BAUD*_DEF   : default baud table indexed by the 2-bit selector
//   - baud_div()  : clocks per oversample tick, CLK_FREQ/(baud*OS)
//   - rx_state_t  : receiver FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OS = 16;

    localparam int unsigned BAUD0_DEF = 2400;
    localparam int unsigned BAUD1_DEF = 4800;
    localparam int unsigned BAUD2_DEF = 9600;
    localparam int unsigned BAUD3_DEF = 19200;

    // Integer division: any remainder is dropped, so the real baud rate runs
    // slightly fast when CLK_FREQ is not an exact multiple of baud*OS.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * OS);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_STOP     = 3'd3,
        ST_BRK_WAIT = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_os_tick.sv
// -----------------------------------------------------------------------------
// uart_os_tick
// Free-running 16x oversample enable generator.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   sel   in  latched baud selector (from the receiver)
//   tick  out one-clk pulse every DIV[sel] clocks
// The counter restarts at 0 whenever sel changes, so the first tick after a
// selector change arrives a full DIV period later.
// -----------------------------------------------------------------------------
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD0    = BAUD0_DEF,
    parameter int unsigned BAUD1    = BAUD1_DEF,
    parameter int unsigned BAUD2    = BAUD2_DEF,
    parameter int unsigned BAUD3    = BAUD3_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    output logic       tick
);

    localparam int unsigned DIV0 = baud_div(CLK_FREQ, BAUD0);
    localparam int unsigned DIV1 = baud_div(CLK_FREQ, BAUD1);
    localparam int unsigned DIV2 = baud_div(CLK_FREQ, BAUD2);
    localparam int unsigned DIV3 = baud_div(CLK_FREQ, BAUD3);

    localparam int unsigned DIV_01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned DIV_23  = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int unsigned DIV_MAX = (DIV_01 > DIV_23) ? DIV_01 : DIV_23;
    localparam int          CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] div_m1;
    logic [1:0]    sel_q;

    always_comb begin
        div_m1 = '0;
        case (sel)
            2'd0:    div_m1 = CW'(DIV0 - 1);
            2'd1:    div_m1 = CW'(DIV1 - 1);
            2'd2:    div_m1 = CW'(DIV2 - 1);
            default: div_m1 = CW'(DIV3 - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            sel_q <= 2'd0;
            tick  <= 1'b0;
        end else if (sel != sel_q) begin
            sel_q <= sel;
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (cnt == div_m1) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// 8N1 UART receiver, LSB first, 16x oversampled in the system clock domain.
//   clk       in  system clock
//   reset     in  synchronous, active-high
//   sel       in  baud selector, latched while IDLE
//   rx        in  asynchronous serial line, idle high
//   rx_data   out last correctly framed byte, held until the next good frame
//   rx_valid  out one-clk strobe when rx_data updates
//   rx_busy   out high from start detection until the FSM re-enters IDLE
//   frame_err out one-clk strobe when the stop bit samples low
//   rx_tick   out the oversample enable
//   state_dbg out current FSM state
//
// Output handshake: rx_valid is a single-cycle strobe with no ready/backpressure;
// rx_data is stable from the strobe until the next strobe. rx_valid and
// frame_err are mutually exclusive and both registered alongside the state
// change.
// -----------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD0    = BAUD0_DEF,
    parameter int unsigned BAUD1    = BAUD1_DEF,
    parameter int unsigned BAUD2    = BAUD2_DEF,
    parameter int unsigned BAUD3    = BAUD3_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       rx_tick,
    output rx_state_t  state_dbg
);

    logic       rx_meta;
    logic       rx_s;
    logic [1:0] sel_lat;
    logic       tick;
    rx_state_t  state;
    logic [3:0] os_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;

    // Two-flop synchroniser; resets to the idle level so reset never looks
    // like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The selector only follows the input while idle, so a mid-frame change
    // takes effect at the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_lat <= 2'd0;
        end else if (state == ST_IDLE) begin
            sel_lat <= sel;
        end
    end

    uart_os_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD0    (BAUD0),
        .BAUD1    (BAUD1),
        .BAUD2    (BAUD2),
        .BAUD3    (BAUD3)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .sel   (sel_lat),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            os_cnt    <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state   <= ST_START;
                            os_cnt  <= 4'd0;
                            rx_busy <= 1'b1;
                        end
                    end
                    ST_START: begin
                        // Half a bit in: confirm the start bit is still low.
                        if (os_cnt == 4'd7) begin
                            if (rx_s) begin
                                state   <= ST_IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state   <= ST_DATA;
                                os_cnt  <= 4'd0;
                                bit_idx <= 3'd0;
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        // os_cnt wraps 15->0 by itself, realigning on mid-bit.
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            shift_reg <= {rx_s, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            if (rx_s) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                                state    <= ST_IDLE;
                                rx_busy  <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BRK_WAIT;
                            end
                        end
                    end
                    ST_BRK_WAIT: begin
                        // A held-low line must go high before a new start.
                        if (rx_s) begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_tick   = tick;
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Drives 8N1 frames onto rx, pushes the expected byte (or an expected framing
// error) into a scoreboard when each frame is issued, and a negedge monitor
// pops and compares whenever the receiver strobes.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 1536000;
    localparam int unsigned B0 = 2400;
    localparam int unsigned B1 = 4800;
    localparam int unsigned B2 = 9600;
    localparam int unsigned B3 = 19200;

    // clock / reset
    logic       clk;
    logic       reset;
    logic [1:0] sel;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       rx_tick;
    rx_state_t  state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD0    (B0),
        .BAUD1    (B1),
        .BAUD2    (B2),
        .BAUD3    (B3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .rx_tick   (rx_tick),
        .state_dbg (state_dbg)
    );

    // scoreboard state
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] last_good;
    int         checks;
    int         errors;
    int         cyc;
    int         valid_cnt;
    int         err_cnt;
    int         busy_cycles;
    int         valid_times[$];

    // Reference: clocks per bit = 16 * floor(CLK_FREQ / (16 * baud)).
    function automatic int bit_clks(input int s);
        int baud;
        case (s)
            0:       baud = B0;
            1:       baud = B1;
            2:       baud = B2;
            default: baud = B3;
        endcase
        return 16 * (CLK_FREQ / (baud * 16));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // monitor
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_busy) busy_cycles++;
            if (rx_valid || frame_err)
                check("valid_err_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (rx_valid) begin
                valid_cnt++;
                valid_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid: got data 0x%0h, expected no strobe", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e});
                    last_good = e;
                end
            end
            if (frame_err) begin
                err_cnt++;
                if (exp_err == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_err: got frame_err=1, expected 0");
                end else begin
                    exp_err--;
                    check("rx_data_held_on_frame_err", {24'd0, rx_data}, {24'd0, last_good});
                end
            end
        end
    end

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        wait_clk(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
        if (stop) exp_q.push_back(d);
        else      exp_err++;
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
        drive_bit(stop, bclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, bc, w;
        logic [7:0] d;
        exp_err = 0; last_good = 8'h00; checks = 0; errors = 0; cyc = 0;
        valid_cnt = 0; err_cnt = 0; busy_cycles = 0;
        reset = 1'b1; rx = 1'b1; sel = 2'd2;
        wait_clk(5);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wait_clk(50);
        bc = bit_clks(2);

        // 1: single frame, busy duration
        v0 = valid_cnt; e0 = err_cnt; busy_cycles = 0;
        send_frame(8'hA5, 1'b1, bc);
        wait_clk(300);
        check("t1_valid_count", valid_cnt - v0, 1);
        check("t1_err_count", err_cnt - e0, 0);
        check_range("t1_busy_cycles", busy_cycles, 1510, 1530);

        // 2: back-to-back frames
        valid_times.delete();
        send_frame(8'h00, 1'b1, bc);
        send_frame(8'hFF, 1'b1, bc);
        wait_clk(300);
        check("t2_valid_count", valid_times.size(), 2);
        if (valid_times.size() == 2)
            check_range("t2_valid_spacing", valid_times[1] - valid_times[0], 1590, 1610);

        // 3: short low glitch is a false start
        v0 = valid_cnt; e0 = err_cnt; busy_cycles = 0;
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 300);
        check("t3_valid_count", valid_cnt - v0, 0);
        check("t3_err_count", err_cnt - e0, 0);
        check_range("t3_busy_cycles", busy_cycles, 70, 90);

        // 4: bad stop bit followed by a held break
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, bc);
        drive_bit(1'b0, 3200);
        check("t4_busy_during_break", {31'd0, rx_busy}, 32'd1);
        drive_bit(1'b1, 100);
        check("t4_busy_after_break", {31'd0, rx_busy}, 32'd0);
        check("t4_err_count", err_cnt - e0, 1);
        check("t4_valid_count", valid_cnt - v0, 0);
        check("t4_rx_data_held", {24'd0, rx_data}, 32'hFF);

        // 5: reset during bit 4 of 0x81, then a clean 0x81
        v0 = valid_cnt;
        d = 8'h81;
        drive_bit(1'b0, bc);
        for (int i = 0; i < 4; i++) drive_bit(d[i], bc);
        drive_bit(d[4], bc / 2);
        reset = 1'b1; rx = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        last_good = 8'h00;
        check("t5_reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("t5_reset_rx_data", {24'd0, rx_data}, 32'h00);
        wait_clk(400);
        check("t5_no_strobe_aborted", valid_cnt - v0, 0);
        send_frame(8'h81, 1'b1, bc);
        wait_clk(300);
        check("t5_valid_count", valid_cnt - v0, 1);

        // random frames with random idle gaps
        v0 = valid_cnt;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, bc);
            wait_clk($urandom_range(0, 300));
        end
        wait_clk(300);
        check("rand_valid_count", valid_cnt - v0, 8);

        // 6: sel change mid-frame, next frame at the new rate
        v0 = valid_cnt;
        fork
            send_frame(8'h5A, 1'b1, bit_clks(2));
            begin
                wait_clk(700);
                sel = 2'd3;
            end
        join
        wait_clk(400);
        send_frame(8'hC3, 1'b1, bit_clks(3));
        wait_clk(300);
        check("t6_valid_count", valid_cnt - v0, 2);

        // drain
        w = 0;
        while (rx_busy && w < 5000) begin
            wait_clk(1);
            w++;
        end
        check("drain_busy_low", {31'd0, rx_busy}, 32'd0);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_err_empty", exp_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
